// File: rtl/sa_pkg.sv
// Shared types and widths for the systolic-array sequencer slice.
package sa_pkg;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      FLUSH,
      COMPUTE,
      DONE
   } sa_seq_state_t;

   localparam int SA_DIM    = 8;
   localparam int SA_DATA_W = 16;
   localparam int SA_IDX_W  = 5;
   localparam int SA_SEL_W  = 4;

endpackage

// File: rtl/sa_sequencer_if.sv
// Valid/ready operand stream from the host/DMA source into the sequencer.
interface sa_sequencer_if;
   import sa_pkg::*;

   logic                 s_valid;
   logic                 s_ready;
   logic [SA_DATA_W-1:0] s_data;

   modport master (output s_valid, output s_data, input s_ready);
   modport slave  (input s_valid, input s_data, output s_ready);

endinterface

// File: rtl/sa_load_addr_gen.sv
// Operand write address: idx counts first, wraps at DEPTH-1 and bumps reg_select.
module sa_load_addr_gen
   import sa_pkg::*;
#(
   parameter int DEPTH    = 32,
   parameter int NUM_REGS = 16
) (
   input  logic                i_clk,
   input  logic                i_rst,
   input  logic                i_clear,
   input  logic                i_advance,
   output logic [SA_IDX_W-1:0] o_idx,
   output logic [SA_SEL_W-1:0] o_sel,
   output logic                o_last
);

   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int SEL_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

   logic [IDX_W-1:0] r_idx;
   logic [SEL_W-1:0] r_sel;
   logic             w_idx_wrap;

   assign w_idx_wrap = (r_idx == IDX_W'(DEPTH - 1));

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_idx <= '0;
         r_sel <= '0;
      end else if (i_clear) begin
         r_idx <= '0;
         r_sel <= '0;
      end else if (i_advance) begin
         if (w_idx_wrap) begin
            r_idx <= '0;
            r_sel <= r_sel + 1'b1;
         end else begin
            r_idx <= r_idx + 1'b1;
         end
      end
   end

   assign o_idx  = SA_IDX_W'(r_idx);
   assign o_sel  = SA_SEL_W'(r_sel);
   assign o_last = w_idx_wrap && (r_sel == SEL_W'(NUM_REGS - 1));

endmodule

// File: rtl/sa_sequencer.sv
// Load/flush/compute/done sequencer for one 8x8 systolic-array matmul.
// Optional SA_SEQ_PERF_EN adds LOAD-cycle and stall-cycle performance counters.
module sa_sequencer
   import sa_pkg::*;
#(
   parameter int DEPTH          = 32,
   parameter int NUM_REGS       = 16,
   parameter int COMPUTE_CYCLES = DEPTH + 2 * SA_DIM
) (
   input  logic                 CLK,
   input  logic                 RST,
   input  logic                 start,
   input  logic                 abort,
   sa_sequencer_if.slave        s_if,
   output logic                 sa_en,
   output logic                 rf_en,
   output logic                 sa_write,
   output logic [SA_IDX_W-1:0]  sa_idx,
   output logic [SA_DATA_W-1:0] sa_din,
   output logic [SA_SEL_W-1:0]  sa_reg_select,
   output logic                 busy,
   output logic                 done
`ifdef SA_SEQ_PERF_EN
   ,
   output logic [31:0]          perf_load_cycles,
   output logic [31:0]          perf_stall_cycles
`endif
);

   localparam int CNT_W = $clog2(COMPUTE_CYCLES + 1);

   sa_seq_state_t        r_state;
   logic                 r_en, r_rf_en, r_write, r_ready, r_busy, r_done;
   logic [SA_IDX_W-1:0]  r_idx;
   logic [SA_DATA_W-1:0] r_din;
   logic [SA_SEL_W-1:0]  r_sel;
   logic [CNT_W-1:0]     r_cnt;

   logic                 w_hs, w_last, w_clear;
   logic [SA_IDX_W-1:0]  w_idx;
   logic [SA_SEL_W-1:0]  w_sel;

   // r_ready is high exactly while in LOAD, so it doubles as the state qualifier.
   assign w_hs    = r_ready && s_if.s_valid;
   assign w_clear = (r_state == IDLE);

   sa_load_addr_gen #(
      .DEPTH    (DEPTH),
      .NUM_REGS (NUM_REGS)
   ) u_addr (
      .i_clk     (CLK),
      .i_rst     (RST),
      .i_clear   (w_clear),
      .i_advance (w_hs),
      .o_idx     (w_idx),
      .o_sel     (w_sel),
      .o_last    (w_last)
   );

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_state <= IDLE;
         r_en    <= 1'b0;
         r_rf_en <= 1'b0;
         r_write <= 1'b0;
         r_ready <= 1'b0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_idx   <= '0;
         r_din   <= '0;
         r_sel   <= '0;
         r_cnt   <= '0;
      end else if (abort) begin
         r_state <= IDLE;
         r_en    <= 1'b0;
         r_rf_en <= 1'b0;
         r_write <= 1'b0;
         r_ready <= 1'b0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (start) begin
                  r_state <= LOAD;
                  r_en    <= 1'b1;
                  r_rf_en <= 1'b1;
                  r_write <= 1'b1;
                  r_ready <= 1'b1;
                  r_busy  <= 1'b1;
               end
            end
            LOAD: begin
               if (w_hs) begin
                  r_din <= s_if.s_data;
                  r_idx <= w_idx;
                  r_sel <= w_sel;
                  if (w_last) begin
                     r_state <= FLUSH;
                     r_ready <= 1'b0;
                  end
               end
            end
            FLUSH: begin
               r_state <= COMPUTE;
               r_write <= 1'b0;
               r_cnt   <= '0;
            end
            COMPUTE: begin
               if (r_cnt == CNT_W'(COMPUTE_CYCLES - 1)) begin
                  r_state <= DONE;
                  r_en    <= 1'b0;
                  r_rf_en <= 1'b0;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            DONE: begin
               r_state <= IDLE;
               r_done  <= 1'b0;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

`ifdef SA_SEQ_PERF_EN
   logic [31:0] r_perf_load, r_perf_stall;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_perf_load  <= '0;
         r_perf_stall <= '0;
      end else if (r_state == IDLE && start && !abort) begin
         r_perf_load  <= '0;
         r_perf_stall <= '0;
      end else if (r_state == LOAD) begin
         if (r_perf_load != '1) r_perf_load <= r_perf_load + 1'b1;
         if (!s_if.s_valid && r_perf_stall != '1) r_perf_stall <= r_perf_stall + 1'b1;
      end
   end

   assign perf_load_cycles  = r_perf_load;
   assign perf_stall_cycles = r_perf_stall;
`endif

   assign s_if.s_ready  = r_ready;
   assign sa_en         = r_en;
   assign rf_en         = r_rf_en;
   assign sa_write      = r_write;
   assign sa_idx        = r_idx;
   assign sa_din        = r_din;
   assign sa_reg_select = r_sel;
   assign busy          = r_busy;
   assign done          = r_done;

endmodule

// File: tb/tb_sa_sequencer.sv
// Bench for sa_sequencer: a default build and a DEPTH=4/COMPUTE_CYCLES=1 build share stimulus,
// each checked every cycle against a job-timeline model.
module tb_sa_sequencer;
   import sa_pkg::*;

   localparam int NR = 16;
   localparam int D0 = 32, C0 = 48;
   localparam int D1 = 4,  C1 = 1;

   logic        CLK = 1'b0;
   logic        RST = 1'b1;
   logic        start = 1'b0;
   logic        abort = 1'b0;
   logic        tb_valid = 1'b0;
   logic [15:0] tb_data = '0;

   always #5 CLK = ~CLK;

   logic        d_en [2], d_rf [2], d_wr [2], d_busy [2], d_done [2];
   logic [4:0]  d_idx [2];
   logic [15:0] d_din [2];
   logic [3:0]  d_sel [2];
   logic [31:0] d_pl [2], d_ps [2];

   sa_sequencer_if u_if0 ();
   sa_sequencer_if u_if1 ();
   assign u_if0.s_valid = tb_valid;
   assign u_if0.s_data  = tb_data;
   assign u_if1.s_valid = tb_valid;
   assign u_if1.s_data  = tb_data;

   sa_sequencer #(.DEPTH(D0), .NUM_REGS(NR), .COMPUTE_CYCLES(C0)) u_dut0 (
      .CLK(CLK), .RST(RST), .start(start), .abort(abort), .s_if(u_if0),
      .sa_en(d_en[0]), .rf_en(d_rf[0]), .sa_write(d_wr[0]), .sa_idx(d_idx[0]),
      .sa_din(d_din[0]), .sa_reg_select(d_sel[0]), .busy(d_busy[0]), .done(d_done[0])
`ifdef SA_SEQ_PERF_EN
      , .perf_load_cycles(d_pl[0]), .perf_stall_cycles(d_ps[0])
`endif
   );

   sa_sequencer #(.DEPTH(D1), .NUM_REGS(NR), .COMPUTE_CYCLES(C1)) u_dut1 (
      .CLK(CLK), .RST(RST), .start(start), .abort(abort), .s_if(u_if1),
      .sa_en(d_en[1]), .rf_en(d_rf[1]), .sa_write(d_wr[1]), .sa_idx(d_idx[1]),
      .sa_din(d_din[1]), .sa_reg_select(d_sel[1]), .busy(d_busy[1]), .done(d_done[1])
`ifdef SA_SEQ_PERF_EN
      , .perf_load_cycles(d_pl[1]), .perf_stall_cycles(d_ps[1])
`endif
   );

`ifndef SA_SEQ_PERF_EN
   assign d_pl[0] = '0;
   assign d_pl[1] = '0;
   assign d_ps[0] = '0;
   assign d_ps[1] = '0;
`endif

   int n_pass = 0;
   int n_total = 0;

   task automatic chk(string nm, int inst, logic [31:0] act, logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s u%0d got %0h expected %0h at %0t", nm, inst, act, exp, $time);
   endtask

   // Job model: a job is a timeline of edges since start was accepted; the
   // phase is derived from how many words have arrived and when the last one did.
   bit          m_job [2];
   int          m_c [2], m_nw [2], m_tlast [2];
   logic [4:0]  m_idx [2];
   logic [3:0]  m_sel [2];
   logic [15:0] m_din [2];
   int unsigned m_pl [2], m_ps [2];

   function automatic int dep(int i); return (i == 0) ? D0 : D1; endfunction
   function automatic int ccy(int i); return (i == 0) ? C0 : C1; endfunction

   // 0 idle, 1 load, 2 flush, 3 compute, 4 done
   function automatic int phase(int i);
      if (!m_job[i]) return 0;
      if (m_tlast[i] < 0 || m_c[i] < m_tlast[i]) return 1;
      if (m_c[i] == m_tlast[i]) return 2;
      if (m_c[i] <= m_tlast[i] + ccy(i)) return 3;
      return 4;
   endfunction

   always @(posedge CLK or posedge RST) begin
      for (int i = 0; i < 2; i++) begin
         int p;
         if (RST) begin
            m_job[i] = 0; m_c[i] = 0; m_nw[i] = 0; m_tlast[i] = -1;
            m_idx[i] = '0; m_sel[i] = '0; m_din[i] = '0; m_pl[i] = 0; m_ps[i] = 0;
         end else begin
            p = phase(i);
            if (p == 1) begin
               m_pl[i]++;
               if (!tb_valid) m_ps[i]++;
            end
            if (abort) m_job[i] = 0;
            else if (p == 0) begin
               if (start) begin
                  m_job[i] = 1; m_c[i] = 0; m_nw[i] = 0; m_tlast[i] = -1;
                  m_pl[i] = 0; m_ps[i] = 0;
               end
            end else if (p == 1) begin
               if (tb_valid) begin
                  m_idx[i] = 5'(m_nw[i] % dep(i));
                  m_sel[i] = 4'(m_nw[i] / dep(i));
                  m_din[i] = tb_data;
                  m_nw[i]++;
                  if (m_nw[i] == dep(i) * NR) m_tlast[i] = m_c[i] + 1;
               end
               m_c[i]++;
            end else if (p == 4) m_job[i] = 0;
            else m_c[i]++;
         end
      end
   end

   always @(negedge CLK) begin
      for (int i = 0; i < 2; i++) begin
         int p;
         p = phase(i);
         chk("sa_en", i, 32'(d_en[i]), 32'(p >= 1 && p <= 3));
         chk("rf_en", i, 32'(d_rf[i]), 32'(p >= 1 && p <= 3));
         chk("sa_write", i, 32'(d_wr[i]), 32'(p == 1 || p == 2));
         chk("s_ready", i, 32'((i == 0) ? u_if0.s_ready : u_if1.s_ready), 32'(p == 1));
         chk("busy", i, 32'(d_busy[i]), 32'(p >= 1 && p <= 3));
         chk("done", i, 32'(d_done[i]), 32'(p == 4));
         chk("sa_idx", i, 32'(d_idx[i]), 32'(m_idx[i]));
         chk("sa_reg_select", i, 32'(d_sel[i]), 32'(m_sel[i]));
         chk("sa_din", i, 32'(d_din[i]), 32'(m_din[i]));
`ifdef SA_SEQ_PERF_EN
         chk("perf_load", i, d_pl[i], m_pl[i]);
         chk("perf_stall", i, d_ps[i], m_ps[i]);
`endif
      end
   end

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   task automatic feed_until(int n, bit toggle);
      int guard;
      guard = 0;
      while (m_nw[0] < n && guard < 3000) begin
         tb_valid = toggle ? ~tb_valid : 1'b1;
         tb_data  = 16'(m_nw[0] + 1);
         step();
         guard++;
      end
      tb_valid = 1'b0;
      if (guard >= 3000) chk("feed_timeout", 0, 32'(m_nw[0]), 32'(n));
   endtask

   task automatic wait_done(output bit found);
      found = 0;
      for (int k = 0; k < 300; k++) begin
         @(negedge CLK);
         if (d_done[0]) begin
            found = 1;
            break;
         end
         @(posedge CLK);
         #1;
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      int  cyc, low, tgt;
      bit  seen, chk33, found;

      repeat (3) @(posedge CLK);
      #1 RST = 1'b0;
      @(negedge CLK);
      chk("reset_en", 0, 32'(d_en[0]), 0);
      chk("reset_busy", 0, 32'(d_busy[0]), 0);

      // Reset in the middle of a load.
      pulse_start();
      feed_until(10, 0);
      RST = 1'b1;
      @(negedge CLK);
      chk("rst_mid_en", 0, 32'(d_en[0]), 0);
      chk("rst_mid_write", 0, 32'(d_wr[0]), 0);
      chk("rst_mid_din", 0, 32'(d_din[0]), 0);
      chk("rst_mid_idx", 0, 32'(d_idx[0]), 0);
      step();
      RST = 1'b0;
      pulse_start();
      feed_until(1, 0);
      @(negedge CLK);
      chk("restart_idx", 0, 32'(d_idx[0]), 0);
      chk("restart_sel", 0, 32'(d_sel[0]), 0);
      chk("restart_din", 0, 32'(d_din[0]), 1);
      step();
      abort = 1'b1;
      step();
      abort = 1'b0;
      step();

      // Back-to-back load with full timeline.
      pulse_start();
      low = 0; seen = 0; chk33 = 0; cyc = 0;
      tb_valid = 1'b1;
      tb_data  = 16'(m_nw[0] + 1);
      for (int i = 0; i < 700; i++) begin
         @(negedge CLK);
         if (d_en[0] && !d_wr[0]) low++;
         if (!chk33 && m_nw[0] == 33) begin
            chk33 = 1;
            chk("word33_sel", 0, 32'(d_sel[0]), 1);
            chk("word33_idx", 0, 32'(d_idx[0]), 0);
            chk("word33_din", 0, 32'(d_din[0]), 33);
         end
         if (d_done[0]) begin
            seen = 1;
            cyc = i;
            break;
         end
         @(posedge CLK);
         #1;
         tb_data = 16'(m_nw[0] + 1);
      end
      tb_valid = 1'b0;
      chk("b2b_done_seen", 0, 32'(seen), 1);
      chk("b2b_start_to_done", 0, 32'(cyc + 2), 1 + 512 + 1 + 48 + 1);
      chk("b2b_write_low", 0, 32'(low), 48);
      chk("b2b_final_idx", 0, 32'(d_idx[0]), 31);
      chk("b2b_final_sel", 0, 32'(d_sel[0]), 15);
      chk("b2b_final_din", 0, 32'(d_din[0]), 512);
      step();
      step();

      // Valid toggling every cycle.
      pulse_start();
      feed_until(512, 1);
      wait_done(found);
      chk("toggle_done_seen", 0, 32'(found), 1);
`ifdef SA_SEQ_PERF_EN
      chk("toggle_stall_range", 0, 32'(d_ps[0] >= 511 && d_ps[0] <= 512), 1);
      chk("toggle_load_sum", 0, d_pl[0], 512 + d_ps[0]);
`endif
      step();
      step();

      // Abort in compute cycle 20.
      pulse_start();
      feed_until(512, 0);
      tgt = m_tlast[0] + 1 + 20;
      for (int k = 0; k < 100 && m_c[0] < tgt; k++) step();
      chk("abort_target_reached", 0, 32'(m_c[0]), 32'(tgt));
      abort = 1'b1;
      step();
      abort = 1'b0;
      @(negedge CLK);
      chk("abort_en", 0, 32'(d_en[0]), 0);
      chk("abort_busy", 0, 32'(d_busy[0]), 0);
      seen = 0;
      for (int k = 0; k < 60; k++) begin
         @(negedge CLK);
         if (d_done[0]) seen = 1;
      end
      chk("abort_no_done", 0, 32'(seen), 0);
      step();

      // Start pulses during load and compute must be ignored.
      pulse_start();
      feed_until(100, 0);
      start = 1'b1; tb_valid = 1'b1; tb_data = 16'(m_nw[0] + 1);
      step();
      start = 1'b0;
      feed_until(300, 0);
      start = 1'b1; tb_valid = 1'b1; tb_data = 16'(m_nw[0] + 1);
      step();
      start = 1'b0;
      feed_until(512, 0);
      repeat (5) step();
      pulse_start();
      wait_done(found);
      chk("ignored_start_done", 0, 32'(found), 1);
      chk("ignored_start_idx", 0, 32'(d_idx[0]), 31);
      chk("ignored_start_din", 0, 32'(d_din[0]), 512);
      step();
      repeat (3) step();

      // start and abort together in IDLE.
      start = 1'b1; abort = 1'b1;
      step();
      start = 1'b0; abort = 1'b0;
      @(negedge CLK);
      chk("start_abort_busy", 0, 32'(d_busy[0]), 0);
      chk("start_abort_en", 0, 32'(d_en[0]), 0);
      repeat (3) step();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
